scie_pipelined: RTL and testbench
=================================

Name: scie_pipelined

Overview:
- Complex-valued FIR filter accelerator for a RISC-V custom-instruction (SCIE) slot.
- The core issues an instruction word with a complex rs1 operand (16-bit real and imaginary) and a 32-bit rs2 operand.
- The block holds programmable complex coefficients and a sample delay line.
- It returns the filtered complex result on rd when a read instruction executes.

Parameters:
- NTAPS, 2, number of FIR taps (coefficient registers and delay-line entries); valid range is 1 or more.
- XLEN, 32, width of the io_insn and io_rs2 ports.
- DW, 16, width of each signed real/imag component.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- io_valid  in  1  instruction valid; all state changes are qualified by it.
- io_insn  in  XLEN  instruction word; only bits [6:0] (the opcode) are decoded.
- io_rs1_real  in  DW  signed real part of operand rs1.
- io_rs1_imag  in  DW  signed imaginary part of operand rs1.
- io_rs2  in  XLEN  unsigned coefficient index (used by the SETC opcode only).
- io_rd_real  out  DW  signed real part of the result.
- io_rd_imag  out  DW  signed imaginary part of the result.

Behaviour:
- State:
  - coef[0..NTAPS-1]: complex DW-bit signed coefficient registers.
  - x[0..NTAPS-1]: complex delay line; x[0] is the newest sample.
  - rd: complex output register.
- Reset (asynchronous, active-high): all coef, all x and rd are cleared to 0. The io_rd outputs read 0 during and immediately after reset.
- Opcode decode on io_insn[6:0], acted on at the rising clock edge only when io_valid=1:
  - 0x0B SETC: if io_rs2 < NTAPS, coef[io_rs2] <= rs1. Otherwise no effect.
  - 0x2B PUSH: x[0] <= rs1 and x[i] <= x[i-1] for i = 1..NTAPS-1. The oldest sample is discarded.
  - 0x5B READ: rd <= sum over i of coef[i]*x[i].
  - Any other opcode, or io_valid=0: no state change; rd holds its value.
- Complex multiply: (a+bi)(c+di) = (ac-bd) + (ad+bc)i.
  - Products and sums are computed at full width.
  - The final real and imag values are truncated to their low DW bits (two's-complement wrap, no saturation).
- Latency:
  - READ: rd is visible on the outputs one clock after the edge that samples the READ. The result uses the coef/x state present before that edge.
  - SETC and PUSH: the new state is used by a READ sampled on the next edge or any later edge.
- rd changes only on a READ. Between READs the outputs are stable.
- Reset asserted mid-sequence clears everything immediately, regardless of clock.
- Only one opcode can be presented per cycle, so simultaneous operations cannot occur.
- Outputs depend only on registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package scie_pkg contains:
  - opcode constants OPC_SETC=7'h0B, OPC_PUSH=7'h2B, OPC_READ=7'h5B;
  - a complex struct type {logic signed [DW-1:0] re, im}.
- Sub-module scie_cmul: a combinational complex multiplier producing full-width products. Instantiate it NTAPS times and sum the outputs in the top level.

Test Plan:
- After reset with no instructions, READ -> rd=(0,0).
- Coefficient load and first output:
  - SETC rs2=0, rs1=(12,-35); SETC rs2=1, rs1=(35,-5); PUSH (40,30); idle 1 cycle; READ.
  - Required: rd=(1530,-1040) one cycle after the READ.
- Second sample: continuing, PUSH (15,-2); idle; READ -> rd=(1660,301), i.e. c0*(15-2i) + c1*(40+30i).
- Gating and index range:
  - Any opcode with io_valid=0 -> no state change; rd remains (1660,301).
  - SETC with rs2=5 -> ignored; a following READ still gives (1660,301).
- Wrap-around: SETC coef0=(32767,0), clear coef1, PUSH (2,0), READ -> rd=(-2,0), the low 16 bits of 65534.
- Reset asserted asynchronously between clock edges -> rd drops to (0,0) at once; a subsequent READ gives (0,0).

Source files
------------

// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE complex FIR accelerator: opcodes and the
// complex sample/coefficient type.
package scie_pkg;

    localparam int CPLX_DW = 16;

    localparam logic [6:0] OPC_SETC = 7'h0B;
    localparam logic [6:0] OPC_PUSH = 7'h2B;
    localparam logic [6:0] OPC_READ = 7'h5B;

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/scie_cmul.sv
// Combinational complex multiplier: (a_re + j a_im) * (b_re + j b_im) at full
// width. Each output carries one extra bit so the sum or difference of two
// products cannot overflow.
module scie_cmul #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [2*DW:0] p_re,
    output logic signed [2*DW:0] p_im
);

    logic signed [2*DW-1:0] ac;
    logic signed [2*DW-1:0] bd;
    logic signed [2*DW-1:0] ad;
    logic signed [2*DW-1:0] bc;

    // Four partial products, then sign-extended combine into real/imag parts.
    always_comb begin
        ac   = a_re * b_re;
        bd   = a_im * b_im;
        ad   = a_re * b_im;
        bc   = a_im * b_re;
        p_re = {ac[2*DW-1], ac} - {bd[2*DW-1], bd};
        p_im = {ad[2*DW-1], ad} + {bc[2*DW-1], bc};
    end

endmodule

// File: rtl/scie_pipelined.sv
// Complex FIR accelerator for a custom-instruction slot. SETC loads a
// coefficient, PUSH shifts a sample into the delay line, READ registers the
// wrapped sum of coef[i]*x[i] into rd. Outputs come straight from rd.
module scie_pipelined
    import scie_pkg::*;
#(
    parameter int NTAPS = 2,
    parameter int XLEN  = 32,
    parameter int DW    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_valid,
    input  logic [XLEN-1:0]      io_insn,
    input  logic [DW-1:0]        io_rs1_real,
    input  logic [DW-1:0]        io_rs1_imag,
    input  logic [XLEN-1:0]      io_rs2,
    output logic [DW-1:0]        io_rd_real,
    output logic [DW-1:0]        io_rd_imag
);

    // Product width and accumulator width with headroom for NTAPS terms.
    localparam int PW = 2 * DW + 1;
    localparam int AW = PW + $clog2(NTAPS + 1);

    logic [6:0] opc;
    logic       unused_insn_hi;

    logic signed [DW-1:0] coef_re_q [NTAPS];
    logic signed [DW-1:0] coef_im_q [NTAPS];
    logic signed [DW-1:0] coef_re_d [NTAPS];
    logic signed [DW-1:0] coef_im_d [NTAPS];
    logic signed [DW-1:0] x_re_q    [NTAPS];
    logic signed [DW-1:0] x_im_q    [NTAPS];
    logic signed [DW-1:0] x_re_d    [NTAPS];
    logic signed [DW-1:0] x_im_d    [NTAPS];
    logic signed [DW-1:0] rd_re_q;
    logic signed [DW-1:0] rd_im_q;
    logic signed [DW-1:0] rd_re_d;
    logic signed [DW-1:0] rd_im_d;

    logic signed [PW-1:0] prod_re [NTAPS];
    logic signed [PW-1:0] prod_im [NTAPS];
    logic signed [AW-1:0] acc_re;
    logic signed [AW-1:0] acc_im;

    assign opc            = io_insn[6:0];
    assign unused_insn_hi = ^io_insn[XLEN-1:7];

    // One complex multiplier per tap, fed by the current coefficient and sample.
    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
        scie_cmul #(
            .DW (DW)
        ) u_cmul (
            .a_re (coef_re_q[g]),
            .a_im (coef_im_q[g]),
            .b_re (x_re_q[g]),
            .b_im (x_im_q[g]),
            .p_re (prod_re[g]),
            .p_im (prod_im[g])
        );
    end

    // Full-width sum of all tap products; truncation happens only at rd.
    always_comb begin
        acc_re = '0;
        acc_im = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc_re = acc_re + AW'(prod_re[i]);
            acc_im = acc_im + AW'(prod_im[i]);
        end
    end

    // Opcode decode: next-state of coefficients, delay line and result.
    always_comb begin
        coef_re_d = coef_re_q;
        coef_im_d = coef_im_q;
        x_re_d    = x_re_q;
        x_im_d    = x_im_q;
        rd_re_d   = rd_re_q;
        rd_im_d   = rd_im_q;
        if (io_valid) begin
            case (opc)
                OPC_SETC: begin
                    // Out-of-range indices match no tap and are dropped.
                    for (int i = 0; i < NTAPS; i++) begin
                        if (io_rs2 == XLEN'(i)) begin
                            coef_re_d[i] = io_rs1_real;
                            coef_im_d[i] = io_rs1_imag;
                        end
                    end
                end
                OPC_PUSH: begin
                    x_re_d[0] = io_rs1_real;
                    x_im_d[0] = io_rs1_imag;
                    for (int i = 1; i < NTAPS; i++) begin
                        x_re_d[i] = x_re_q[i-1];
                        x_im_d[i] = x_im_q[i-1];
                    end
                end
                OPC_READ: begin
                    rd_re_d = acc_re[DW-1:0];
                    rd_im_d = acc_im[DW-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_re_q[i] <= '0;
                coef_im_q[i] <= '0;
                x_re_q[i]    <= '0;
                x_im_q[i]    <= '0;
            end
            rd_re_q <= '0;
            rd_im_q <= '0;
        end else begin
            coef_re_q <= coef_re_d;
            coef_im_q <= coef_im_d;
            x_re_q    <= x_re_d;
            x_im_q    <= x_im_d;
            rd_re_q   <= rd_re_d;
            rd_im_q   <= rd_im_d;
        end
    end

    assign io_rd_real = rd_re_q;
    assign io_rd_imag = rd_im_q;

endmodule

// File: tb/tb_scie_pipelined.sv
// Bench for scie_pipelined: directed scenarios plus randomized instruction
// streams compared against an arithmetic model of the filter.
module tb_scie_pipelined;
    import scie_pkg::*;

    localparam int NT   = 2;
    localparam int XLEN = 32;
    localparam int DW   = 16;

    logic            clock;
    logic            reset;
    logic            io_valid;
    logic [XLEN-1:0] io_insn;
    logic [DW-1:0]   io_rs1_real;
    logic [DW-1:0]   io_rs1_imag;
    logic [XLEN-1:0] io_rs2;
    logic [DW-1:0]   io_rd_real;
    logic [DW-1:0]   io_rd_imag;

    int n_checks;
    int n_errors;

    // Reference state: plain integers, x[0] newest.
    int m_cre [NT];
    int m_cim [NT];
    int m_xre [NT];
    int m_xim [NT];
    int m_rre;
    int m_rim;

    scie_pipelined #(
        .NTAPS (NT),
        .XLEN  (XLEN),
        .DW    (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_insn     (io_insn),
        .io_rs1_real (io_rs1_real),
        .io_rs1_imag (io_rs1_imag),
        .io_rs2      (io_rs2),
        .io_rd_real  (io_rd_real),
        .io_rd_imag  (io_rd_imag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap16(input longint v);
        return int'(shortint'(v[15:0]));
    endfunction

    function automatic int s16(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_cre[i] = 0; m_cim[i] = 0; m_xre[i] = 0; m_xim[i] = 0;
        end
        m_rre = 0;
        m_rim = 0;
    endtask

    // Apply one instruction to the model using the spec's rules.
    task automatic model_step(input logic v, input logic [6:0] opc,
                              input int re, input int im, input logic [31:0] idx);
        longint sr, si;
        if (!v) return;
        if (opc == OPC_SETC) begin
            if (idx < NT) begin
                m_cre[idx] = re;
                m_cim[idx] = im;
            end
        end else if (opc == OPC_PUSH) begin
            for (int i = NT - 1; i > 0; i--) begin
                m_xre[i] = m_xre[i-1];
                m_xim[i] = m_xim[i-1];
            end
            m_xre[0] = re;
            m_xim[0] = im;
        end else if (opc == OPC_READ) begin
            sr = 0;
            si = 0;
            for (int i = 0; i < NT; i++) begin
                sr += longint'(m_cre[i]) * m_xre[i] - longint'(m_cim[i]) * m_xim[i];
                si += longint'(m_cre[i]) * m_xim[i] + longint'(m_cim[i]) * m_xre[i];
            end
            m_rre = wrap16(sr);
            m_rim = wrap16(si);
        end
    endtask

    // Present one instruction for one clock edge; return #1 after that edge.
    task automatic issue(input logic v, input logic [6:0] opc,
                         input int re, input int im, input logic [31:0] idx);
        logic [31:0] w;
        @(negedge clock);
        w           = $urandom();
        w[6:0]      = opc;
        io_valid    = v;
        io_insn     = w;
        io_rs1_real = re[DW-1:0];
        io_rs1_imag = im[DW-1:0];
        io_rs2      = idx;
        @(posedge clock);
        model_step(v, opc, re, im, idx);
        #1;
        io_valid = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input int er, input int ei);
        chk({tag, "_re"}, s16(io_rd_real), er);
        chk({tag, "_im"}, s16(io_rd_imag), ei);
    endtask

    initial begin
        logic [6:0]  opc;
        logic [31:0] idx;
        int          re, im, sel;

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        io_valid    = 1'b0;
        io_insn     = '0;
        io_rs1_real = '0;
        io_rs1_imag = '0;
        io_rs2      = '0;
        model_reset();

        #2;
        chk_rd("in_reset", 0, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_rd("after_reset", 0, 0);

        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("read_zero", 0, 0);

        // Coefficient load and first output.
        issue(1'b1, OPC_SETC, 12, -35, 0);
        issue(1'b1, OPC_SETC, 35, -5, 1);
        issue(1'b1, OPC_PUSH, 40, 30, 0);
        issue(1'b0, 7'h00, 0, 0, 0);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("first_out", 1530, -1040);

        // Second sample.
        issue(1'b1, OPC_PUSH, 15, -2, 0);
        issue(1'b0, 7'h00, 0, 0, 0);
        chk_rd("hold_before_read", 1530, -1040);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("second_out", 1660, 301);

        // Gated opcodes and out-of-range SETC change nothing.
        issue(1'b0, OPC_PUSH, 100, 100, 0);
        issue(1'b0, OPC_SETC, 7, 7, 0);
        issue(1'b0, OPC_READ, 0, 0, 0);
        chk_rd("gated_hold", 1660, 301);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("gated_read", 1660, 301);
        issue(1'b1, OPC_SETC, 99, 99, 5);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("setc_oob", 1660, 301);
        issue(1'b1, 7'h33, 0, 0, 0);
        chk_rd("other_opc", 1660, 301);

        // Wrap-around of the truncated sum.
        issue(1'b1, OPC_SETC, 32767, 0, 0);
        issue(1'b1, OPC_SETC, 0, 0, 1);
        issue(1'b1, OPC_PUSH, 2, 0, 0);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("wrap", -2, 0);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      opc = OPC_SETC;
            else if (sel < 6) opc = OPC_PUSH;
            else if (sel < 9) opc = OPC_READ;
            else              opc = 7'($urandom());
            idx = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, NT));
            re  = int'(shortint'($urandom_range(0, 65535)));
            im  = int'(shortint'($urandom_range(0, 65535)));
            issue(($urandom_range(0, 5) != 0), opc, re, im, idx);
            chk_rd("rand", m_rre, m_rim);
        end

        // Asynchronous reset between edges.
        issue(1'b1, OPC_SETC, 1, 0, 0);
        issue(1'b1, OPC_SETC, 0, 0, 1);
        issue(1'b1, OPC_PUSH, 5, 3, 0);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("pre_async", 5, 3);
        #2;
        reset = 1'b1;
        #1;
        chk_rd("async_reset", 0, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("read_after_async", 0, 0);
        issue(1'b1, OPC_SETC, 3, 0, 0);
        issue(1'b1, OPC_READ, 0, 0, 0);
        chk_rd("x_cleared", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
